// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register plus writeback data selection. Captures the
//   instruction leaving EX, steers the synchronous-read memory data of the
//   addressed region into a load value (shift + byte/half/word extraction),
//   and picks the final writeback value. A LIVE/HELD state machine freezes the
//   load value in a hold register while the stage is stalled, so wb_data
//   stays stable even when the memory outputs move underneath it.
//
//   Optional feature: define MEM_MISALIGN_CHECK_EN to flag misaligned LH/LHU/LW
//   loads on wb_misaligned and suppress their register write.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold stage / invalidate captured instruction
//   ex_valid, ex_instr  upstream valid and instruction (funct3, rd)
//   ex_alu_res, ex_pc   ALU result (load address) and PC
//   ex_reg_we           instruction writes rd
//   ex_wb_sel           00 ALU, 01 load, 10 PC+4, 11 zero
//   dmem/bios/mmio_dout memory read data, valid one cycle after the address
//   wb_valid, wb_rd, wb_we, wb_data, wb_misaligned   writeback outputs
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_instr,
  input  logic [WIDTH-1:0] ex_alu_res,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_reg_we,
  input  logic [1:0]       ex_wb_sel,
  input  logic [WIDTH-1:0] dmem_dout,
  input  logic [WIDTH-1:0] bios_dout,
  input  logic [WIDTH-1:0] mmio_dout,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_we,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_misaligned
);

  typedef enum logic [0:0] {LIVE = 1'b0, HELD = 1'b1} state_t;

  state_t           state_r, state_next_s;
  logic             valid_r;
  logic [2:0]       funct3_r;
  logic [4:0]       rd_r;
  logic             reg_we_r;
  logic [1:0]       wb_sel_r;
  logic [WIDTH-1:0] alu_res_r;
  logic [WIDTH-1:0] pc4_r;
  logic [3:0]       region_r;
  logic [1:0]       offset_r;
  logic [WIDTH-1:0] hold_r;

  logic [WIDTH-1:0] src_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] load_live_s;
  logic [WIDTH-1:0] load_s;
  logic             misaligned_s;
  logic             unused_s;

  // Instruction bits other than funct3/rd are not needed in this stage.
  assign unused_s = ^{ex_instr[WIDTH-1:15], ex_instr[6:0]};

  // Byte/half/word extraction selected by the load funct3.
  function automatic logic [WIDTH-1:0] extract_load(input logic [2:0] f3,
                                                    input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    case (f3)
      3'b000:  r = {{(WIDTH-8){w[7]}}, w[7:0]};
      3'b001:  r = {{(WIDTH-16){w[15]}}, w[15:0]};
      3'b010:  r = w;
      3'b100:  r = {{(WIDTH-8){1'b0}}, w[7:0]};
      3'b101:  r = {{(WIDTH-16){1'b0}}, w[15:0]};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Pipeline register: flush beats stall, stall keeps every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= 1'b0;
      funct3_r  <= 3'b000;
      rd_r      <= 5'd0;
      reg_we_r  <= 1'b0;
      wb_sel_r  <= 2'b00;
      alu_res_r <= {WIDTH{1'b0}};
      pc4_r     <= {WIDTH{1'b0}};
      region_r  <= 4'b0000;
      offset_r  <= 2'b00;
    end else if (flush) begin
      valid_r   <= 1'b0;
    end else if (!stall) begin
      valid_r   <= ex_valid;
      funct3_r  <= ex_instr[14:12];
      rd_r      <= ex_instr[11:7];
      reg_we_r  <= ex_reg_we;
      wb_sel_r  <= ex_wb_sel;
      alu_res_r <= ex_alu_res;
      pc4_r     <= ex_pc + WIDTH'(4);
      region_r  <= ex_alu_res[WIDTH-1 -: 4];
      offset_r  <= ex_alu_res[1:0];
    end
  end

  // Hold state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LIVE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Hold state next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LIVE: begin
        if (stall && !flush) state_next_s = HELD;
        else                 state_next_s = LIVE;
      end
      HELD: begin
        if (!stall || flush) state_next_s = LIVE;
        else                 state_next_s = HELD;
      end
      default: state_next_s = LIVE;
    endcase
  end

  // Freeze the load value on entry to HELD; memory outputs may change later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= {WIDTH{1'b0}};
    end else if (state_r == LIVE && stall && !flush) begin
      hold_r <= load_live_s;
    end
  end

  // Region decode of the registered address.
  always_comb begin
    src_s = {WIDTH{1'b0}};
    case (region_r)
      4'b0001: src_s = dmem_dout;
      4'b0100: src_s = bios_dout;
      4'b1000: src_s = mmio_dout;
      default: src_s = {WIDTH{1'b0}};
    endcase
  end

  // Offset is at most 3 bytes, so the shift never reaches WIDTH.
  assign shifted_s   = src_s >> {offset_r, 3'b000};
  assign load_live_s = extract_load(funct3_r, shifted_s);
  assign load_s      = (state_r == HELD) ? hold_r : load_live_s;

  // Writeback data select.
  always_comb begin
    wb_data = {WIDTH{1'b0}};
    case (wb_sel_r)
      2'b00:   wb_data = alu_res_r;
      2'b01:   wb_data = load_s;
      2'b10:   wb_data = pc4_r;
      default: wb_data = {WIDTH{1'b0}};
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Half loads need even offsets, word loads need offset 0.
  always_comb begin
    misaligned_s = 1'b0;
    if (wb_sel_r == 2'b01) begin
      case (funct3_r)
        3'b001, 3'b101: misaligned_s = offset_r[0];
        3'b010:         misaligned_s = (offset_r != 2'b00);
        default:        misaligned_s = 1'b0;
      endcase
    end else begin
      misaligned_s = 1'b0;
    end
  end
  assign wb_misaligned = valid_r & misaligned_s;
`else
  assign misaligned_s  = 1'b0;
  assign wb_misaligned = 1'b0;
`endif

  assign wb_valid = valid_r;
  assign wb_rd    = rd_r;
  assign wb_we    = valid_r & reg_we_r & (rd_r != 5'd0) & ~misaligned_s;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed scenarios for the listed load/stall/flush/reset cases followed
//   by randomized traffic, all compared against a transaction-level model
//   that holds the instruction in the writeback slot plus a frozen load value.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_reg_we;
  logic [31:0] ex_instr, ex_alu_res, ex_pc, dmem_dout, bios_dout, mmio_dout;
  logic [1:0]  ex_wb_sel;
  logic        wb_valid, wb_we, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          v;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] pc;
    bit          we;
    logic [1:0]  sel;
  } rec_t;

  rec_t        m;
  bit          m_held;
  logic [31:0] m_hold;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_alu_res(ex_alu_res),
    .ex_pc(ex_pc), .ex_reg_we(ex_reg_we), .ex_wb_sel(ex_wb_sel),
    .dmem_dout(dmem_dout), .bios_dout(bios_dout), .mmio_dout(mmio_dout),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .wb_misaligned(wb_misaligned)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Load value from the region/offset/funct3 rules, using plain arithmetic.
  function automatic logic [31:0] ref_load(rec_t r, logic [31:0] dm, logic [31:0] bi, logic [31:0] mm);
    int unsigned region, off, f3;
    logic [31:0] src, sh, b;
    region = r.alu >> 28;
    off    = r.alu % 4;
    f3     = (r.instr >> 12) & 7;
    if (region == 1)      src = dm;
    else if (region == 4) src = bi;
    else if (region == 8) src = mm;
    else                  src = 32'd0;
    sh = src >> (8 * off);
    case (f3)
      0: begin b = sh & 32'hFF;   return b - ((b >= 32'd128)   ? 32'd256     : 32'd0); end
      1: begin b = sh & 32'hFFFF; return b - ((b >= 32'd32768) ? 32'h1_0000 : 32'd0); end
      2: return sh;
      4: return sh & 32'hFF;
      5: return sh & 32'hFFFF;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_mis(rec_t r);
`ifdef MEM_MISALIGN_CHECK_EN
    int unsigned f3, off;
    if (r.sel != 2'b01) return 1'b0;
    f3  = (r.instr >> 12) & 7;
    off = r.alu % 4;
    return ((f3 == 1 || f3 == 5) && (off % 2 == 1)) || (f3 == 2 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge with inputs already driven: check, clock, update model.
  task automatic tick;
    bit          mis, ewe;
    logic [31:0] ed;
    #1;
    mis = m.v && ref_mis(m);
    ewe = m.v && m.we && (((m.instr >> 7) & 32'd31) != 0) && !mis;
    check_eq("wb_valid", {31'd0, wb_valid}, {31'd0, m.v});
    check_eq("wb_we", {31'd0, wb_we}, {31'd0, ewe});
    check_eq("wb_misaligned", {31'd0, wb_misaligned}, {31'd0, mis});
    if (m.v) begin
      case (m.sel)
        2'b00:   ed = m.alu;
        2'b01:   ed = m_held ? m_hold : ref_load(m, dmem_dout, bios_dout, mmio_dout);
        2'b10:   ed = m.pc + 32'd4;
        default: ed = 32'd0;
      endcase
      check_eq("wb_rd", {27'd0, wb_rd}, (m.instr >> 7) & 32'd31);
      check_eq("wb_data", wb_data, ed);
    end
    @(posedge clk);
    if (rst) begin
      m      = '{v: 1'b0, instr: 32'd0, alu: 32'd0, pc: 32'd0, we: 1'b0, sel: 2'b00};
      m_held = 1'b0;
      m_hold = 32'd0;
    end else if (flush) begin
      m.v    = 1'b0;
      m_held = 1'b0;
    end else if (stall) begin
      if (!m_held) begin
        m_hold = ref_load(m, dmem_dout, bios_dout, mmio_dout);
        m_held = 1'b1;
      end
    end else begin
      m      = '{v: ex_valid, instr: ex_instr, alu: ex_alu_res, pc: ex_pc, we: ex_reg_we, sel: ex_wb_sel};
      m_held = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_ex(input bit v, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input bit we, input logic [1:0] sel);
    ex_valid   = v;
    ex_instr   = {17'd0, f3, rd, 7'b0000011};
    ex_alu_res = alu;
    ex_pc      = pc;
    ex_reg_we  = we;
    ex_wb_sel  = sel;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ex(1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0, 2'b00);
    dmem_dout = 32'd0; bios_dout = 32'd0; mmio_dout = 32'd0;
    m      = '{v: 1'b0, instr: 32'd0, alu: 32'd0, pc: 32'd0, we: 1'b0, sel: 2'b00};
    m_held = 1'b0;
    m_hold = 32'd0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_we", {31'd0, wb_we}, 32'd0);
    check_eq("rst_rd", {27'd0, wb_rd}, 32'd0);
    check_eq("rst_data", wb_data, 32'd0);
    check_eq("rst_mis", {31'd0, wb_misaligned}, 32'd0);
    rst = 1'b0;

    // LB offset 3 from dmem, rd=5
    set_ex(1'b1, 3'b000, 5'd5, 32'h1000_0003, 32'h100, 1'b1, 2'b01);
    tick;
    dmem_dout = 32'h80FF_1234;
    set_ex(1'b1, 3'b101, 5'd6, 32'h4000_0002, 32'h104, 1'b1, 2'b01);
    #1;
    check_eq("lb_data", wb_data, 32'hFFFF_FF80);
    check_eq("lb_we", {31'd0, wb_we}, 32'd1);
    tick;
    // LHU offset 2 from bios, then the same load in unmapped region 2
    bios_dout = 32'hBEEF_0000;
    set_ex(1'b1, 3'b101, 5'd6, 32'h2000_0002, 32'h108, 1'b1, 2'b01);
    #1;
    check_eq("lhu_bios", wb_data, 32'h0000_BEEF);
    tick;
    #1;
    check_eq("lhu_unmapped", wb_data, 32'd0);

    // LW then a 3-cycle stall while dmem changes
    set_ex(1'b1, 3'b010, 5'd8, 32'h1000_0000, 32'h200, 1'b1, 2'b01);
    tick;
    dmem_dout = 32'h1122_3344;
    stall = 1'b1;
    set_ex(1'b1, 3'b010, 5'd9, 32'h1000_0004, 32'h204, 1'b1, 2'b01);
    #1;
    check_eq("stall_c1", wb_data, 32'h1122_3344);
    tick;
    dmem_dout = 32'hDEAD_BEEF;
    #1;
    check_eq("stall_c2", wb_data, 32'h1122_3344);
    tick;
    #1;
    check_eq("stall_c3", wb_data, 32'h1122_3344);
    tick;
    stall = 1'b0;
    tick;
    #1;
    check_eq("release_data", wb_data, 32'hDEAD_BEEF);
    check_eq("release_rd", {27'd0, wb_rd}, 32'd9);

    // flush+stall on ADD rd=7, then JAL at the top of the address space
    set_ex(1'b1, 3'b000, 5'd7, 32'd123, 32'h300, 1'b1, 2'b00);
    stall = 1'b1; flush = 1'b1;
    tick;
    stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, 3'b000, 5'd1, 32'd0, 32'hFFFF_FFFC, 1'b1, 2'b10);
    #1;
    check_eq("flush_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("flush_we", {31'd0, wb_we}, 32'd0);
    tick;
    #1;
    check_eq("jal_wrap", wb_data, 32'd0);

    // LH at offset 1
    set_ex(1'b1, 3'b001, 5'd10, 32'h1000_0001, 32'h400, 1'b1, 2'b01);
    tick;
    dmem_dout = 32'h00FF_EE00;
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    check_eq("lh_mis", {31'd0, wb_misaligned}, 32'd1);
    check_eq("lh_we", {31'd0, wb_we}, 32'd0);
`else
    check_eq("lh_mis", {31'd0, wb_misaligned}, 32'd0);
    check_eq("lh_we", {31'd0, wb_we}, 32'd1);
    check_eq("lh_data", wb_data, 32'hFFFF_FFEE);
`endif
    tick;

    // reset while HELD, then a write to x0
    set_ex(1'b1, 3'b010, 5'd11, 32'h1000_0000, 32'h500, 1'b1, 2'b01);
    tick;
    stall = 1'b1;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; stall = 1'b0;
    set_ex(1'b1, 3'b000, 5'd0, 32'd5, 32'h600, 1'b1, 2'b00);
    #1;
    check_eq("hrst_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("hrst_we", {31'd0, wb_we}, 32'd0);
    check_eq("hrst_rd", {27'd0, wb_rd}, 32'd0);
    check_eq("hrst_data", wb_data, 32'd0);
    check_eq("hrst_mis", {31'd0, wb_misaligned}, 32'd0);
    tick;
    #1;
    check_eq("x0_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("x0_we", {31'd0, wb_we}, 32'd0);
    tick;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] region;
      case ($urandom_range(0, 4))
        0:       region = 32'h1;
        1:       region = 32'h4;
        2:       region = 32'h8;
        3:       region = 32'h2;
        default: region = 32'h0;
      endcase
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      set_ex(1'($urandom), 3'($urandom), 5'($urandom),
             (region << 28) | ($urandom & 32'h0FFF_FFFF),
             ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
             1'($urandom), 2'($urandom));
      dmem_dout = $urandom;
      bios_dout = $urandom;
      mmio_dout = $urandom;
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
